// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU initiator. Builds {cmd, A[, B]} frames from the UART RX byte stream,
// fires the ALU for one cycle, and returns the two-byte result to UART TX.
module alu_cmd_ctrl #(
   parameter int OPER_WIDTH  = 8,
   parameter int OUT_WIDTH   = 2 * OPER_WIDTH,
   parameter int RES_TIMEOUT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [OPER_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [OPER_WIDTH-1:0] ALU_A,
   output logic [OPER_WIDTH-1:0] ALU_B,
   output logic [3:0]            ALU_FUN,
   output logic                  ALU_EN,
   input  logic [OUT_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_VALID,
   output logic [OPER_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  CMD_ERR,
   output logic                  BUSY,
   output logic [2:0]            DBG_STATE
);

   // Handshakes: RX_D_VLD is a one-cycle strobe with no back-pressure. A TX byte moves on
   // the rising edge where TX_D_VLD=1 and TX_BUSY=0; while TX_BUSY=1 valid and data hold.

   typedef enum logic [2:0] {
      IDLE, GET_A, GET_B, EXEC, WAIT_RES, SEND_LO, GAP, SEND_HI
   } state_t;

   localparam int               CNT_W    = $clog2(RES_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_TIMEOUT - 1);

   state_t               state, state_nx;
   logic [CNT_W-1:0]     wait_cnt;
   logic [OUT_WIDTH-1:0] result;
   logic [3:0]           rx_fun;
   logic                 cmd_legal, rx_unary, fun_unary, cmd_err_nx;

   assign rx_fun    = RX_P_DATA[3:0];
   assign cmd_legal = (RX_P_DATA[OPER_WIDTH-1:4] == '0) && (rx_fun != 4'hF);
   assign rx_unary  = (rx_fun == 4'hD) || (rx_fun == 4'hE);
   assign fun_unary = (ALU_FUN == 4'hD) || (ALU_FUN == 4'hE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         ALU_A    <= '0;
         ALU_B    <= '0;
         ALU_FUN  <= '0;
         result   <= '0;
         wait_cnt <= '0;
         CMD_ERR  <= 1'b0;
      end else begin
         state    <= state_nx;
         CMD_ERR  <= cmd_err_nx;
         wait_cnt <= (state == WAIT_RES) ? wait_cnt + 1'b1 : '0;
         if (state == IDLE && RX_D_VLD && cmd_legal) begin
            ALU_FUN <= rx_fun;
            if (rx_unary) ALU_B <= '0;
         end
         if (state == GET_A && RX_D_VLD) ALU_A <= RX_P_DATA;
         if (state == GET_B && RX_D_VLD) ALU_B <= RX_P_DATA;
         if (state == WAIT_RES && OUT_VALID) result <= ALU_OUT;
      end
   end

   always_comb begin
      state_nx   = state;
      cmd_err_nx = 1'b0;
      ALU_EN     = 1'b0;
      TX_D_VLD   = 1'b0;
      TX_P_DATA  = '0;
      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (cmd_legal) state_nx   = GET_A;
               else           cmd_err_nx = 1'b1;
            end
         end
         GET_A: if (RX_D_VLD) state_nx = fun_unary ? EXEC : GET_B;
         GET_B: if (RX_D_VLD) state_nx = EXEC;
         EXEC: begin
            ALU_EN     = 1'b1;
            cmd_err_nx = RX_D_VLD;
            state_nx   = WAIT_RES;
         end
         WAIT_RES: begin
            // Abort after RES_TIMEOUT cycles without a result; a dropped byte in the
            // same cycle merges into the single error pulse.
            cmd_err_nx = RX_D_VLD;
            if (OUT_VALID) begin
               state_nx = SEND_LO;
            end else if (wait_cnt == CNT_LAST) begin
               state_nx   = IDLE;
               cmd_err_nx = 1'b1;
            end
         end
         SEND_LO: begin
            TX_D_VLD   = 1'b1;
            TX_P_DATA  = result[OPER_WIDTH-1:0];
            cmd_err_nx = RX_D_VLD;
            if (!TX_BUSY) state_nx = GAP;
         end
         GAP: begin
            cmd_err_nx = RX_D_VLD;
            state_nx   = SEND_HI;
         end
         SEND_HI: begin
            TX_D_VLD   = 1'b1;
            TX_P_DATA  = result[OUT_WIDTH-1:OPER_WIDTH];
            cmd_err_nx = RX_D_VLD;
            if (!TX_BUSY) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign BUSY      = (state != IDLE);
   assign DBG_STATE = state;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized bench for alu_cmd_ctrl: a frame-level reference model predicts ALU commands,
// TX bytes and error pulses; bench processes play the ALU and the UART TX side.
module tb_alu_cmd_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] RX_P_DATA;
   logic       RX_D_VLD;
   logic [7:0] ALU_A, ALU_B;
   logic [3:0] ALU_FUN;
   logic       ALU_EN;
   logic [15:0] ALU_OUT;
   logic       OUT_VALID;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_BUSY;
   logic       CMD_ERR;
   logic       BUSY;
   logic [2:0] DBG_STATE;

   alu_cmd_ctrl #(.OPER_WIDTH(8), .OUT_WIDTH(16), .RES_TIMEOUT(4)) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
      .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .CMD_ERR(CMD_ERR), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic [19:0] cmd_q[$];
   int          exp_err  = 0;
   int          err_seen = 0;
   bit          tx_hold  = 1'b0;
   bit          alu_mute = 1'b0;
   int          alu_lat  = 1;
   bit          hold_prev = 1'b0;
   logic [7:0]  hold_data = '0;
   int          gap_chk  = 0;
   bit          en_prev  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a,
                                           input logic [7:0] b);
      logic [15:0] wa, wb;
      wa = {8'h00, a};
      wb = {8'h00, b};
      case (f)
         4'h0: return wa + wb;
         4'h1: return wa - wb;
         4'h2: return wa * wb;
         4'h3: return (b != 0) ? wa / wb : 16'h0000;
         4'h4: return wa & wb;
         4'h5: return wa | wb;
         4'h6: return {8'h00, ~(a & b)};
         4'h7: return {8'h00, ~(a | b)};
         4'h8: return wa ^ wb;
         4'h9: return {8'h00, ~(a ^ b)};
         4'hA: return (a == b) ? 16'h0001 : 16'h0000;
         4'hB: return (a > b)  ? 16'h0002 : 16'h0000;
         4'hC: return (a < b)  ? 16'h0003 : 16'h0000;
         4'hD: return wa >> 1;
         4'hE: return wa << 1;
         default: return 16'h0000;
      endcase
   endfunction

   // ---------------- UART TX side: random busy, transfer scoreboard ----------------
   initial begin
      TX_BUSY = 1'b0;
      forever begin
         @(posedge CLK); #1;
         TX_BUSY = tx_hold || ($urandom_range(0, 3) == 0);
      end
   end

   initial forever begin
      @(negedge CLK);
      if (!RST) begin
         if (gap_chk == 1) begin
            check("gap_low", {31'b0, TX_D_VLD}, 0);
            gap_chk = 2;
         end else if (gap_chk == 2) begin
            check("gap_one_cycle", {31'b0, TX_D_VLD}, 1);
            gap_chk = 0;
         end
         if (hold_prev) begin
            check("hold_vld", {31'b0, TX_D_VLD}, 1);
            check("hold_data", {24'b0, TX_P_DATA}, {24'b0, hold_data});
         end
         if (TX_D_VLD && !TX_BUSY) begin
            check("tx_expected", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
               if (exp_q.size() == 2) gap_chk = 1;
               check("tx_byte", {24'b0, TX_P_DATA}, {24'b0, exp_q.pop_front()});
            end
         end
         hold_prev = TX_D_VLD && TX_BUSY;
         hold_data = TX_P_DATA;
         if (CMD_ERR) err_seen++;
         if (ALU_EN) check("alu_en_one_cycle", {31'b0, en_prev}, 0);
         en_prev = ALU_EN;
      end else begin
         hold_prev = 1'b0;
         gap_chk   = 0;
         en_prev   = 1'b0;
      end
   end

   // ---------------- ALU stand-in: checks commands, returns a result ----------------
   initial begin
      logic [19:0] sav;
      logic [15:0] res;
      int          lat;
      OUT_VALID = 1'b0;
      ALU_OUT   = '0;
      forever begin
         @(negedge CLK);
         if (ALU_EN && !RST) begin
            check("alu_en_expected", {31'b0, cmd_q.size() != 0}, 1);
            if (cmd_q.size() != 0)
               check("alu_cmd", {12'b0, ALU_FUN, ALU_A, ALU_B}, {12'b0, cmd_q.pop_front()});
            if (!alu_mute) begin
               sav = {ALU_FUN, ALU_A, ALU_B};
               res = alu_ref(ALU_FUN, ALU_A, ALU_B);
               lat = alu_lat;
               @(posedge CLK); #1;
               repeat (lat - 1) begin
                  ALU_OUT = 16'($urandom);
                  @(posedge CLK); #1;
               end
               ALU_OUT   = res;
               OUT_VALID = 1'b1;
               @(negedge CLK);
               check("alu_inputs_hold", {12'b0, ALU_FUN, ALU_A, ALU_B}, {12'b0, sav});
               @(posedge CLK); #1;
               OUT_VALID = 1'b0;
               ALU_OUT   = 16'($urandom);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      step();
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   task automatic rand_gap();
      repeat ($urandom_range(0, 2)) step();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         if (!BUSY && exp_q.size() == 0) break;
         step();
      end
      check("idle_reached", {31'b0, BUSY}, 0);
      check("tx_all_sent", exp_q.size(), 0);
      step();
      step();
      check("cmd_err_count", err_seen, exp_err);
      check("alu_cmds_used", cmd_q.size(), 0);
   endtask

   task automatic check_reset_outputs();
      @(negedge CLK);
      check("rst_alu_a", {24'b0, ALU_A}, 0);
      check("rst_alu_b", {24'b0, ALU_B}, 0);
      check("rst_alu_fun", {28'b0, ALU_FUN}, 0);
      check("rst_tx_data", {24'b0, TX_P_DATA}, 0);
      check("rst_ctrl", {28'b0, ALU_EN, TX_D_VLD, CMD_ERR, BUSY}, 0);
      @(posedge CLK); #1;
   endtask

   // One frame through the reference model: expected command, bytes and error pulses.
   task automatic run_frame(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                            input int drop_d, input bit mute, input int hold_cyc);
      logic [7:0]  be;
      logic [15:0] r;
      bit          un;
      un = (fun == 4'hD) || (fun == 4'hE);
      be = un ? 8'h00 : b;
      r  = alu_ref(fun, a, be);
      cmd_q.push_back({fun, a, be});
      if (mute) begin
         alu_mute = 1'b1;
         exp_err++;
      end else begin
         exp_q.push_back(r[7:0]);
         exp_q.push_back(r[15:8]);
      end
      if (hold_cyc > 0) tx_hold = 1'b1;
      send_byte({4'h0, fun});
      rand_gap();
      send_byte(a);
      if (!un) begin
         rand_gap();
         send_byte(b);
      end
      if (drop_d >= 0) begin
         repeat (drop_d) step();
         send_byte(8'($urandom));
         exp_err++;
      end
      if (hold_cyc > 0) begin
         repeat (hold_cyc) step();
         if (!mute) begin
            check("held_lo_vld", {31'b0, TX_D_VLD}, 1);
            check("held_lo_data", {24'b0, TX_P_DATA}, {24'b0, r[7:0]});
         end
         tx_hold = 1'b0;
      end
      wait_idle();
      alu_mute = 1'b0;
   endtask

   // Runs a frame until the low byte is gone, then either drops a byte or resets in SEND_HI.
   task automatic hi_phase(input bit do_rst);
      logic [15:0] r;
      r = alu_ref(4'h1, 8'h90, 8'h25);
      cmd_q.push_back({4'h1, 8'h90, 8'h25});
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
      send_byte(8'h01);
      send_byte(8'h90);
      send_byte(8'h25);
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK);
         if (exp_q.size() == 1) break;
      end
      check("lo_byte_sent", exp_q.size(), 1);
      tx_hold = 1'b1;
      #1;
      step();
      if (do_rst) begin
         step();
         exp_q.delete();
         RST = 1'b1;
         step();
         RST = 1'b0;
         check_reset_outputs();
      end else begin
         send_byte(8'hA7);
         exp_err++;
         repeat (3) step();
      end
      tx_hold = 1'b0;
      wait_idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] ill;
      int         dd, hc;
      bit         mu;
      RST       = 1'b1;
      RX_D_VLD  = 1'b0;
      RX_P_DATA = '0;
      step();
      step();
      check_reset_outputs();
      RST = 1'b0;
      step();

      alu_lat = 1;
      run_frame(4'h0, 8'h12, 8'h34, -1, 1'b0, 0);
      run_frame(4'h2, 8'hFF, 8'hFF, -1, 1'b0, 12);
      run_frame(4'hE, 8'h81, 8'h5C, -1, 1'b0, 0);
      send_byte(8'h0F);
      exp_err++;
      step();
      send_byte(8'h13);
      exp_err++;
      step();
      run_frame(4'h4, 8'hF0, 8'h3C, -1, 1'b0, 0);
      run_frame(4'hA, 8'h77, 8'h77, 0, 1'b0, 0);
      hi_phase(1'b0);
      run_frame(4'h0, 8'h55, 8'h66, -1, 1'b1, 0);
      hi_phase(1'b1);
      run_frame(4'h8, 8'hA5, 8'h0F, -1, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         alu_lat = $urandom_range(1, 3);
         if ($urandom_range(0, 4) == 0) begin
            ill = ($urandom_range(0, 1) == 1) ? 8'h0F
                  : {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            send_byte(ill);
            exp_err++;
            rand_gap();
         end
         mu = ($urandom_range(0, 7) == 0);
         dd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
         hc = (!mu && $urandom_range(0, 5) == 0) ? $urandom_range(4, 8) : 0;
         run_frame(4'($urandom_range(0, 14)), 8'($urandom), 8'($urandom), dd, mu, hc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command-side initiator for the system ALU. Assembles command frames from the UART receive byte stream and drives the ALU operand/function/enable interface. Captures the registered ALU result and returns it as two bytes to the UART transmit interface through a valid/busy handshake. Sits between UART RX/TX and the ALU in the final system.

Parameters:
OPER_WIDTH, 8, operand and UART byte width
OUT_WIDTH, 16, ALU result width; fixed at 2*OPER_WIDTH
RES_TIMEOUT, 4, max cycles waited for OUT_VALID after ALU_EN before abort (>=2)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
RX_P_DATA  in  OPER_WIDTH  received byte, valid only with RX_D_VLD
RX_D_VLD  in  1  one-cycle strobe per received byte
ALU_A  out  OPER_WIDTH  operand A to ALU
ALU_B  out  OPER_WIDTH  operand B to ALU
ALU_FUN  out  4  ALU function code
ALU_EN  out  1  ALU enable, exactly one cycle per command
ALU_OUT  in  OUT_WIDTH  registered ALU result
OUT_VALID  in  1  result-valid from ALU
TX_P_DATA  out  OPER_WIDTH  byte to UART TX
TX_D_VLD  out  1  TX byte valid
TX_BUSY  in  1  UART TX cannot accept
CMD_ERR  out  1  one-cycle error pulse
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: RST sampled high -> next cycle state=IDLE; ALU_A, ALU_B, ALU_FUN, TX_P_DATA = 0; ALU_EN, TX_D_VLD, CMD_ERR, BUSY = 0; timeout counter = 0. Applies from any state, including mid-frame and mid-send; a partly sent result is abandoned.
- Frame: byte0 = command {4'h0, FUN}; then A; then B. FUN 4'hD/4'hE (shifts) are unary: frame is byte0, A only; ALU_B driven 0.
- Illegal byte0: upper nibble != 0, or FUN = 4'hF -> CMD_ERR pulse next cycle, stay IDLE, byte discarded.
- States: IDLE -> GET_A -> GET_B (binary only) -> EXEC -> WAIT_RES -> SEND_LO -> GAP -> SEND_HI -> IDLE.
- IDLE: on RX_D_VLD with legal byte0, latch FUN -> GET_A.
- GET_A/GET_B: on RX_D_VLD, latch byte into ALU_A/ALU_B; last operand -> EXEC. No inter-byte timeout.
- EXEC: one cycle; ALU_EN=1 with ALU_A/B/FUN stable; -> WAIT_RES. ALU_A/B/FUN hold their values until the next EXEC.
- WAIT_RES: counter starts at 0 on entry. On OUT_VALID=1, capture ALU_OUT into a result register -> SEND_LO. Nominal ALU latency is 1 cycle, so OUT_VALID arrives the first WAIT_RES cycle. If the counter reaches RES_TIMEOUT without OUT_VALID -> CMD_ERR pulse, -> IDLE, nothing sent.
- Handshake: a byte transfers on the rising edge where TX_D_VLD=1 and TX_BUSY=0. While TX_BUSY=1, TX_D_VLD and TX_P_DATA hold stable.
- SEND_LO: TX_P_DATA = result[7:0], TX_D_VLD=1 until transfer -> GAP.
- GAP: TX_D_VLD=0 for one cycle so TX can raise TX_BUSY -> SEND_HI.
- SEND_HI: TX_P_DATA = result[15:8], same handshake; on transfer -> IDLE with TX_D_VLD=0 next cycle.
- RX_D_VLD in EXEC, WAIT_RES, SEND_LO, GAP, SEND_HI: byte dropped, CMD_ERR pulse, current operation unaffected.
- RX_D_VLD on the same cycle as the IDLE return from SEND_HI is treated as arriving in SEND_HI and is dropped.
- Simultaneous CMD_ERR causes (drop + timeout) -> single pulse.
- Result bytes are sent unmodified. Compare results 1/2/3 are sent as 0x01/0x02/0x03 low, 0x00 high.

Test Plan:
- RX 0x00,0x12,0x34 -> one ALU_EN cycle with A=0x12, B=0x34, FUN=0; ALU_OUT=0x0046 -> TX 0x46 then 0x00, BUSY low after.
- RX 0x02,0xFF,0xFF with TX_BUSY held high for 10 cycles -> TX_D_VLD=1, TX_P_DATA=0x01 stable throughout; then 0x01 and 0xFE transfer, with one GAP cycle between them.
- RX 0x0E,0x81 -> EXEC after 2nd byte, ALU_B=0, FUN=0xE; result 0x0102 -> TX 0x02, 0x01.
- RX 0x0F, then 0x13 -> two CMD_ERR pulses, no ALU_EN; following 0x04,0xF0,0x3C -> result 0x0030 sent normally.
- Extra RX byte during SEND_HI -> CMD_ERR pulse, high byte still sent correctly. OUT_VALID withheld 4 cycles -> CMD_ERR, IDLE, no TX.
- RST high for 1 cycle in SEND_HI with TX_BUSY=1 -> next cycle all outputs 0, IDLE; new frame processed normally.
